// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: single-byte READ/WRITE controller for a 23LC512-class SPI SRAM.
// The datapath issues one request at a time. The controller sends a 32-bit SPI mode 0
// frame at clk/2 and reports completion with a busy/done handshake.
// Optional macro MEM_SEQ_READ_EN: after a read, chip select stays low. A read of the
// next address then needs only 8 more data bits.
module spi_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memReq,
  input  logic                  memWrite,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memWriteData,
  output logic [DATA_WIDTH-1:0] memReadBus,
  output logic                  memBusy,
  output logic                  memDone,
  output logic                  spiCsN,
  output logic                  spiSclk,
  output logic                  spiMosi,
  input  logic                  spiMiso
);

`ifdef MEM_SEQ_READ_EN
  typedef enum logic [2:0] {StIdle, StShift, StDone, StHold, StClose} state_e;
`else
  typedef enum logic [2:0] {StIdle, StShift, StDone} state_e;
`endif

  state_e                r_state;
  logic [31:0]           r_frame;     // bit 31 is the bit currently on MOSI
  logic [4:0]            r_bit_cnt;
  logic                  r_phase;     // 0: SCLK low half, 1: SCLK high half
  logic [DATA_WIDTH-2:0] r_rx;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_read_bus;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cs_n;
  logic                  r_sclk;

  logic [31:0]           w_req_frame;
  logic [DATA_WIDTH-1:0] w_rx_next;

  // The SPI address is 16 bits wide. The CPU address is zero-extended by one bit.
  assign w_req_frame = memWrite ? {8'h02, 1'b0, memAddr, memWriteData}
                                : {8'h03, 1'b0, memAddr, 8'h00};
  assign w_rx_next   = {r_rx, spiMiso};

`ifdef MEM_SEQ_READ_EN
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [31:0]           w_lat_frame;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic                  w_continue;

  assign w_lat_frame = r_write ? {8'h02, 1'b0, r_addr, r_wdata}
                               : {8'h03, 1'b0, r_addr, 8'h00};
  assign w_addr_next = r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  // The burst may continue only on a read of the next address, with no wrap at the top.
  assign w_continue  = !memWrite && (memAddr == w_addr_next) && !(&r_addr);
`endif

  // Transaction sequencer: accept, shift the frame, complete and (optionally) hold the burst
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_frame    <= '0;
      r_bit_cnt  <= '0;
      r_phase    <= 1'b0;
      r_rx       <= '0;
      r_write    <= 1'b0;
      r_read_bus <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b0;
`ifdef MEM_SEQ_READ_EN
      r_addr     <= '0;
      r_wdata    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (memReq) begin
            r_state   <= StShift;
            r_write   <= memWrite;
`ifdef MEM_SEQ_READ_EN
            r_addr    <= memAddr;
            r_wdata   <= memWriteData;
`endif
            r_frame   <= w_req_frame;
            r_bit_cnt <= 5'd31;
            r_phase   <= 1'b0;
            r_cs_n    <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        StShift: begin
          if (!r_phase) begin
            r_sclk  <= 1'b1;
            r_phase <= 1'b1;
          end else begin
            r_sclk  <= 1'b0;
            r_phase <= 1'b0;
            r_rx    <= w_rx_next[DATA_WIDTH-2:0];
            r_frame <= {r_frame[30:0], 1'b0};
            if (r_bit_cnt == 5'd0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              if (!r_write) begin
                r_read_bus <= w_rx_next;
              end
`ifdef MEM_SEQ_READ_EN
              // After a read, CS stays low so the next read can continue the burst.
              r_cs_n <= r_write;
`else
              r_cs_n <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end
        end
        StDone: begin
          r_busy <= 1'b0;
`ifdef MEM_SEQ_READ_EN
          r_state <= r_write ? StIdle : StHold;
`else
          r_state <= StIdle;
`endif
        end
`ifdef MEM_SEQ_READ_EN
        StHold: begin
          if (memReq) begin
            r_addr  <= memAddr;
            r_write <= memWrite;
            r_wdata <= memWriteData;
            r_busy  <= 1'b1;
            if (w_continue) begin
              // The device auto-increments. Clock out only 8 more data bits.
              r_state   <= StShift;
              r_frame   <= '0;
              r_bit_cnt <= 5'd7;
              r_phase   <= 1'b0;
            end else begin
              r_state <= StClose;
              r_cs_n  <= 1'b1;
            end
          end
        end
        StClose: begin
          r_state   <= StShift;
          r_cs_n    <= 1'b0;
          r_frame   <= w_lat_frame;
          r_bit_cnt <= 5'd31;
          r_phase   <= 1'b0;
        end
`endif
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b0;
        end
      endcase
    end
  end

  assign memReadBus = r_read_bus;
  assign memBusy    = r_busy;
  assign memDone    = r_done;
  assign spiCsN     = r_cs_n;
  assign spiSclk    = r_sclk;
  assign spiMosi    = r_frame[31];

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Testbench for spi_mem_ctrl: SPI SRAM device model, reference model and scoreboard.
// It builds for either setting of MEM_SEQ_READ_EN.
module tb_spi_mem_ctrl;

`ifdef MEM_SEQ_READ_EN
  localparam bit SeqEn = 1'b1;
`else
  localparam bit SeqEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        memReq;
  logic        memWrite;
  logic [14:0] memAddr;
  logic [7:0]  memWriteData;
  logic [7:0]  memReadBus;
  logic        memBusy;
  logic        memDone;
  logic        spiCsN;
  logic        spiSclk;
  logic        spiMosi;
  logic        spiMiso = 1'b0;

  always #5 clk = ~clk;

  spi_mem_ctrl #(
    .ADDR_WIDTH(15),
    .DATA_WIDTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memReq      (memReq),
    .memWrite    (memWrite),
    .memAddr     (memAddr),
    .memWriteData(memWriteData),
    .memReadBus  (memReadBus),
    .memBusy     (memBusy),
    .memDone     (memDone),
    .spiCsN      (spiCsN),
    .spiSclk     (spiSclk),
    .spiMosi     (spiMosi),
    .spiMiso     (spiMiso)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SPI SRAM device model (sequential mode, SPI mode 0) ----------------
  logic [7:0]  slave_mem [0:65535];
  logic [23:0] slv_shift;
  logic [7:0]  slv_cmd;
  logic [15:0] slv_addr;
  int          slv_cnt = 0;
  logic [31:0] txn_mosi = '0;
  int          txn_edges = 0;
  int          txn_cs_hi = 0;

  // At mid-cycle, SCLK high means the DUT is in its high half-bit. Capture MOSI here and
  // present the MISO bit that the DUT samples on the closing edge.
  always @(negedge clk) begin
    logic [15:0] a;
    logic [7:0]  b;
    if (spiCsN) begin
      slv_cnt = 0;
    end else if (spiSclk) begin
      slv_shift = {slv_shift[22:0], spiMosi};
      txn_mosi  = {txn_mosi[30:0], spiMosi};
      txn_edges++;
      if (slv_cnt == 23) begin
        slv_cmd  = slv_shift[23:16];
        slv_addr = slv_shift[15:0];
      end
      if (slv_cnt >= 24 && slv_cmd == 8'h03) begin
        a = slv_addr + 16'((slv_cnt - 24) / 8);
        b = slave_mem[a];
        spiMiso = b[3'(7 - ((slv_cnt - 24) % 8))];
      end else begin
        spiMiso = 1'b0;
      end
      if (slv_cnt == 31 && slv_cmd == 8'h02) slave_mem[slv_addr] = slv_shift[7:0];
      slv_cnt++;
    end
  end

  // ---------------- Reference model and scoreboard ----------------
  typedef struct {
    int          req_cyc;
    int          lat;
    logic [7:0]  rdata;
    logic [31:0] mosi;
    int          edges;
    int          cs_hi;
    logic        cs_done;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  last_read = 8'h00;
  bit          hold_valid = 1'b0;
  logic [14:0] hold_addr = '0;

  // Monitor: on each completion, pop the expected result and compare it.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      txn_mosi  = '0;
      txn_edges = 0;
      txn_cs_hi = 0;
    end else if (memDone) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got memDone=1, expected no completion (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("latency", 32'(cyc - e.req_cyc), 32'(e.lat));
        check("read_bus", {24'h0, memReadBus}, {24'h0, e.rdata});
        check("mosi_stream", txn_mosi, e.mosi);
        check("sclk_edges", 32'(txn_edges), 32'(e.edges));
        check("cs_high_while_busy", 32'(txn_cs_hi), 32'(e.cs_hi));
        check("cs_in_done", {31'h0, spiCsN}, {31'h0, e.cs_done});
      end
      txn_mosi  = '0;
      txn_edges = 0;
      txn_cs_hi = 0;
    end else if (memBusy && spiCsN) begin
      txn_cs_hi++;
    end
  end

  // Issue one request at the first cycle the controller accepts it. Call at a negedge.
  task automatic issue(input logic wr, input logic [14:0] addr, input logic [7:0] wd,
                       output int req_cyc);
    exp_t e;
    int   w = 0;
    while (memBusy && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait_bound", {31'h0, memBusy}, 32'h0);
    e.req_cyc = cyc;
    req_cyc   = cyc;
    if (SeqEn && hold_valid && !wr && hold_addr != 15'h7FFF &&
        int'(addr) == int'(hold_addr) + 1) begin
      e.lat = 17; e.edges = 8; e.mosi = 32'h0; e.cs_hi = 0;
    end else begin
      e.lat   = (SeqEn && hold_valid) ? 66 : 65;
      e.cs_hi = (SeqEn && hold_valid) ? 1 : 0;
      e.edges = 32;
      e.mosi  = wr ? {8'h02, 1'b0, addr, wd} : {8'h03, 1'b0, addr, 8'h00};
    end
    if (wr) begin
      ref_mem[{1'b0, addr}] = wd;
      e.rdata = last_read;
    end else begin
      last_read = ref_mem[{1'b0, addr}];
      e.rdata   = last_read;
    end
    e.cs_done  = SeqEn ? wr : 1'b1;
    hold_valid = SeqEn && !wr;
    hold_addr  = addr;
    exp_q.push_back(e);
    memReq       = 1'b1;
    memWrite     = wr;
    memAddr      = addr;
    memWriteData = wd;
    @(negedge clk);
    memReq = 1'b0;
  endtask

  initial begin
    int          t0;
    int          t1;
    int          w;
    logic [14:0] a;
    logic        wr;

    for (int i = 0; i < 65536; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i]   = slave_mem[i];
    end
    reset = 1'b1; memReq = 1'b0; memWrite = 1'b0; memAddr = '0; memWriteData = '0;
    repeat (3) @(negedge clk);
    check("reset_cs_n", {31'h0, spiCsN}, 32'h1);
    check("reset_sclk", {31'h0, spiSclk}, 32'h0);
    check("reset_mosi", {31'h0, spiMosi}, 32'h0);
    check("reset_busy", {31'h0, memBusy}, 32'h0);
    check("reset_done", {31'h0, memDone}, 32'h0);
    check("reset_read_bus", {24'h0, memReadBus}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Abort a read in the middle of bit 17. No completion may follow.
    memReq = 1'b1; memWrite = 1'b0; memAddr = 15'h0042;
    @(negedge clk);
    memReq = 1'b0;
    repeat (28) @(negedge clk);
    check("midshift_busy_before_reset", {31'h0, memBusy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs_n", {31'h0, spiCsN}, 32'h1);
    check("abort_sclk", {31'h0, spiSclk}, 32'h0);
    check("abort_busy", {31'h0, memBusy}, 32'h0);
    check("abort_read_bus", {24'h0, memReadBus}, 32'h0);
    reset = 1'b0;
    last_read = 8'h00; hold_valid = 1'b0;
    repeat (80) @(negedge clk);

    // Directed read and write.
    slave_mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
    issue(1'b0, 15'h1234, 8'h00, t0);
    issue(1'b1, 15'h7FFF, 8'h3C, t0);

    // A request while busy is dropped. The re-issue is taken 66 cycles after the first.
    issue(1'b0, 15'h0200, 8'h00, t0);
    repeat (8) @(negedge clk);
    memReq = 1'b1; memWrite = 1'b1; memAddr = 15'h0555; memWriteData = 8'hEE;
    @(negedge clk);
    memReq = 1'b0;
    issue(1'b0, 15'h0300, 8'h00, t1);
    check("reissue_accept_cycle", 32'(t1 - t0), 32'd66);

    // Burst continue and the non-continue cases.
    issue(1'b0, 15'h0100, 8'h00, t0);
    issue(1'b0, 15'h0101, 8'h00, t0);
    issue(1'b0, 15'h7FFF, 8'h00, t0);
    issue(1'b0, 15'h0000, 8'h00, t0);
    issue(1'b1, 15'h0001, 8'h77, t0);
    issue(1'b0, 15'h0001, 8'h00, t0);

    // Random mix, biased toward sequential reads.
    a = 15'($urandom);
    for (int i = 0; i < 40; i++) begin
      wr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) a = a + 15'd1;
      else a = 15'($urandom);
      issue(wr, a, 8'($urandom), t0);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
